// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save stream accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StResolve,
    StDone
  } csa_state_e;

  function automatic int unsigned acc_width(input int unsigned width, input int unsigned max_ops);
    return width + $clog2(max_ops);
  endfunction

  function automatic int unsigned res_cycles(input int unsigned acc_w, input int unsigned chunk);
    return (acc_w + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational W-bit 3:2 compressor row; carry_o is unshifted (weight of bit i is 2^(i+1)).
module csa_row #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  always_comb begin
    sum_o   = a_i ^ b_i ^ c_i;
    carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand adder: carry-save accumulation, then chunked carry-propagate resolve.
// Optional macro CSA_SIGNED_EN selects two's complement operands with sign-headroom overflow.
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_OPS = 16,
  parameter int unsigned CHUNK   = 4,
  localparam int unsigned ACC_W   = acc_width(WIDTH, MAX_OPS),
  localparam int unsigned RES_CYC = res_cycles(ACC_W, CHUNK),
  localparam int unsigned CNT_W   = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_sum_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic             out_ovf_o
);

  localparam int unsigned PAD_W = RES_CYC * CHUNK;
  localparam int unsigned KW    = (RES_CYC > 1) ? $clog2(RES_CYC) : 1;

  csa_state_e       state_q;
  logic [ACC_W-1:0] acc_s_q, acc_c_q;
  logic [PAD_W-1:0] res_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic [KW-1:0]    k_q;
  logic             cin_q;

  logic [ACC_W-1:0] x_ext, row_sum, row_carry, row_carry_sh;
  logic [CHUNK:0]   chunk_sum;
  logic             sign_ovf;

`ifdef CSA_SIGNED_EN
  assign x_ext    = {{(ACC_W - WIDTH){in_data_i[WIDTH-1]}}, in_data_i};
  assign sign_ovf = (state_q == StDone) && (res_q[ACC_W-1] != res_q[ACC_W-2]);
`else
  assign x_ext    = {{(ACC_W - WIDTH){1'b0}}, in_data_i};
  assign sign_ovf = 1'b0;
`endif

  csa_row #(
    .W(ACC_W)
  ) u_row (
    .a_i    (acc_s_q),
    .b_i    (acc_c_q),
    .c_i    (x_ext),
    .sum_o  (row_sum),
    .carry_o(row_carry)
  );

  assign row_carry_sh = ACC_W'({row_carry, 1'b0});

  // Accumulators shift right each resolve cycle, so the live chunk always sits in the low bits.
  assign chunk_sum = {1'b0, acc_s_q[CHUNK-1:0]} + {1'b0, acc_c_q[CHUNK-1:0]} +
                     {{CHUNK{1'b0}}, cin_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_s_q <= '0;
      acc_c_q <= '0;
      res_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
      cin_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            acc_s_q <= x_ext;
            acc_c_q <= '0;
            count_q <= CNT_W'(1);
            k_q     <= '0;
            cin_q   <= 1'b0;
            state_q <= in_last_i ? StResolve : StAccum;
          end
        end
        StAccum: begin
          if (in_valid_i) begin
            acc_s_q <= row_sum;
            acc_c_q <= row_carry_sh;
            if (count_q == CNT_W'(MAX_OPS)) ovf_q <= 1'b1;
            else count_q <= count_q + CNT_W'(1);
            k_q     <= '0;
            cin_q   <= 1'b0;
            if (in_last_i) state_q <= StResolve;
          end
        end
        StResolve: begin
          acc_s_q <= acc_s_q >> CHUNK;
          acc_c_q <= acc_c_q >> CHUNK;
          cin_q   <= chunk_sum[CHUNK];
          // Result fills from the top so chunk 0 lands at bit 0 after the final shift.
          res_q   <= (res_q >> CHUNK) | (PAD_W'(chunk_sum[CHUNK-1:0]) << (PAD_W - CHUNK));
          k_q     <= k_q + KW'(1);
          if (k_q == KW'(RES_CYC - 1)) state_q <= StDone;
        end
        StDone: begin
          if (out_ready_i) begin
            acc_s_q <= '0;
            acc_c_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle) || (state_q == StAccum);
  assign out_valid_o = (state_q == StDone);
  assign out_sum_o   = res_q[ACC_W-1:0];
  assign out_count_o = count_q;
  assign out_ovf_o   = ovf_q | sign_ovf;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench for csa_stream_accumulator (unsigned build, WIDTH=8 MAX_OPS=16 CHUNK=4).
module tb_csa_stream_accumulator;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MAX_OPS = 16;
  localparam int unsigned CHUNK   = 4;
  localparam int unsigned ACC_W   = 12;
  localparam int unsigned RES_CYC = 3;
  localparam int unsigned CNT_W   = 5;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  logic prev_valid = 1'b0;

  csa_stream_accumulator #(
    .WIDTH  (WIDTH),
    .MAX_OPS(MAX_OPS),
    .CHUNK  (CHUNK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_sum_o  (out_sum),
    .out_count_o(out_count),
    .out_ovf_o  (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the operand is taken.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    if (last) last_acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [ACC_W-1:0] s, input logic [CNT_W-1:0] c, input logic o);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: latency on the rising edge of out_valid, result contents on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid && !prev_valid)
        chk("latency", 32'(cyc - last_acc_cyc), 32'(RES_CYC + 1));
      prev_valid <= out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_sum", 32'(out_sum), 32'(e.sum));
          chk("out_count", 32'(out_count), 32'(e.cnt));
          chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    int n;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(1);

    // Three 0xFF operands.
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    push(12'h2FD, 5'd3, 1'b0);
    gap(6);

    // Single operand burst.
    send(8'hA5, 1'b1);
    push(12'h0A5, 5'd1, 1'b0);
    gap(6);

    // Gaps inside a burst.
    send(8'h10, 1'b0);
    gap(3);
    send(8'h20, 1'b0);
    gap(2);
    send(8'h30, 1'b1);
    push(12'h060, 5'd3, 1'b0);
    gap(6);

    // Exactly MAX_OPS operands: 16*255 = 0xFF0.
    for (int i = 0; i < 16; i++) send(8'hFF, (i == 15));
    push(12'hFF0, 5'd16, 1'b0);
    gap(6);

    // 17 operands: count saturates, overflow flagged, 4335 mod 4096 = 0x0EF.
    for (int i = 0; i < 17; i++) send(8'hFF, (i == 16));
    push(12'h0EF, 5'd16, 1'b1);
    gap(6);

    // Consumer stall in DONE with in_valid pulses that must be ignored.
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    push(12'h033, 5'd2, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(out_sum), 32'h033);
      chk("stall_count", 32'(out_count), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      in_data  = 8'hEE;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    gap(1);
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    push(12'h003, 5'd2, 1'b0);
    gap(6);

    // Asynchronous reset mid-resolve; no result expected from this burst.
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_sum", 32'(out_sum), 32'd0);
    chk("abort_out_count", 32'(out_count), 32'd0);
    chk("abort_out_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(1);
    send(8'h05, 1'b0);
    send(8'h07, 1'b1);
    push(12'h00C, 5'd2, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    gap(2);
    chk("queue_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
